spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_shift_reg.sv | 29 ++
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: opcodes, controller states and frame geometry.
package spi_pkg;

    localparam int FRAME_W   = 10;
    localparam int PAYLOAD_W = 8;
    localparam int CNT_W     = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_OUT,
        ST_TURN,
        ST_SHIFT_IN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register; new bits enter at the LSB from ser_i.
// Load has priority over shift; one-cycle update, no backpressure.
module spi_shift_reg #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] par_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_dat_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[W-2:0], ser_i};
        end
    end

    assign par_o = sr_q;

endmodule

// File: rtl/spi_master.sv
// SPI command master: sends a 10-bit {cmd,data} frame, and for read-data frames
// waits TURN_CYCLES then captures one byte from MISO. start is dropped while busy.
module spi_master
    import spi_pkg::*;
#(
    parameter int TURN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [PAYLOAD_W-1:0] data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 busy,
    output logic                 done,
    output logic [PAYLOAD_W-1:0] rd_data,
    output logic                 rd_valid
);

    localparam logic [CNT_W-1:0] OUT_LOAD  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] IN_LOAD   = CNT_W'(PAYLOAD_W - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rd_op_q, rd_op_d;
    logic [PAYLOAD_W-1:0] rd_data_q, rd_data_d;

    logic                 sr_load;
    logic                 sr_shift;
    logic [FRAME_W-1:0]   sr_q;
    logic                 sr_unused;

    // One register serves both directions: the frame shifts out of the MSB while
    // MISO shifts into the LSB, so after SHIFT_IN the byte sits in the low 8 bits.
    spi_shift_reg #(
        .W(FRAME_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load_i    (sr_load),
        .load_dat_i({cmd, data}),
        .shift_i   (sr_shift),
        .ser_i     (MISO),
        .par_o     (sr_q)
    );

    assign sr_unused = sr_q[FRAME_W-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_op_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_op_q   <= rd_op_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_op_d   = rd_op_q;
        rd_data_d = rd_data_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT_OUT;
                    cnt_d   = OUT_LOAD;
                    rd_op_d = (cmd == CMD_RD_DATA);
                    sr_load = 1'b1;
                end
            end
            ST_SHIFT_OUT: begin
                sr_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = rd_op_q ? ST_TURN : ST_DONE;
                    cnt_d   = rd_op_q ? TURN_LOAD : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT_IN;
                    cnt_d   = IN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                sr_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (rd_op_q) begin
                    rd_data_d = sr_q[PAYLOAD_W-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rd_data bypasses the holding register in DONE so it is valid alongside rd_valid.
    always_comb begin
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rd_valid = 1'b0;
        rd_data  = rd_data_q;
        unique case (state_q)
            ST_SHIFT_OUT: begin
                SS_n = 1'b0;
                MOSI = sr_q[FRAME_W-1];
                busy = 1'b1;
            end
            ST_TURN, ST_SHIFT_IN: begin
                SS_n = 1'b0;
                busy = 1'b1;
            end
            ST_DONE: begin
                done     = 1'b1;
                rd_valid = rd_op_q;
                if (rd_op_q) begin
                    rd_data = sr_q[PAYLOAD_W-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed plus randomized frames against a RAM-backed slave model; the model
// tracks the slave's address pointer and memory and predicts every output.
module tb_spi_master;

    localparam int TURN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] addr_m;
    logic [7:0] exp_rd;

    spi_master #(
        .TURN_CYCLES(TURN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cmd     (cmd),
        .data    (data),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from the IDLE cycle that carries start through DONE.
    // inj: frame cycle index on which a stray start is pulsed (-1 for none).
    // rst_at: frame cycle index on which reset is asserted (-1 for none).
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                             input int inj, input int rst_at);
        logic [9:0] frame;
        logic [7:0] byte_v;
        bit         rd;
        bit         aborted;
        int         len;
        frame   = {c, d};
        rd      = (c == 2'b11);
        len     = rd ? 18 + TURN : 10;
        byte_v  = mem[addr_m];
        aborted = 1'b0;

        @(negedge clk);
        check("idle_ssn", 8'(SS_n), 8'd1);
        check("idle_busy", 8'(busy), 8'd0);
        start = 1'b1;
        cmd   = c;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        cmd   = 2'($urandom_range(0, 3));
        data  = 8'($urandom);

        for (int i = 0; i < len; i++) begin
            check("frame_ssn", 8'(SS_n), 8'd0);
            check("frame_mosi", 8'(MOSI), (i < 10) ? 8'(frame[9-i]) : 8'd0);
            check("frame_busy", 8'(busy), 8'd1);
            check("frame_done", 8'(done), 8'd0);
            start = (i == inj);
            if (rd && i >= 10 + TURN) MISO = byte_v[7-(i-10-TURN)];
            else                      MISO = 1'($urandom);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_ssn", 8'(SS_n), 8'd1);
                check("rst_done", 8'(done), 8'd0);
                check("rst_rdvalid", 8'(rd_valid), 8'd0);
                check("rst_rddata", rd_data, 8'h00);
                check("rst_busy", 8'(busy), 8'd0);
                aborted = 1'b1;
                start   = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        MISO  = 1'b0;

        if (aborted) begin
            exp_rd = 8'h00;
        end else begin
            case (c)
                2'b00: addr_m = d;
                2'b01: mem[addr_m] = d;
                2'b10: addr_m = d;
                default: exp_rd = byte_v;
            endcase
            check("done_pulse", 8'(done), 8'd1);
            check("done_ssn", 8'(SS_n), 8'd1);
            check("done_busy", 8'(busy), 8'd0);
            check("done_rdvalid", 8'(rd_valid), 8'(rd));
            check("done_rddata", rd_data, exp_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        addr_m = 8'h00;
        exp_rd = 8'h00;
        rst    = 1'b1;
        start  = 1'b0;
        cmd    = 2'b00;
        data   = 8'h00;
        MISO   = 1'b0;

        #12;
        check("reset_ssn", 8'(SS_n), 8'd1);
        check("reset_mosi", 8'(MOSI), 8'd0);
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_done", 8'(done), 8'd0);
        check("reset_rdvalid", 8'(rd_valid), 8'd0);
        check("reset_rddata", rd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Write-address A5, then a write/read-back of 3C.
        run_frame(2'b00, 8'hA5, -1, -1);
        run_frame(2'b00, 8'h20, -1, -1);
        run_frame(2'b01, 8'h3C, -1, -1);
        run_frame(2'b11, 8'h00, -1, -1);
        check("rd_3c", exp_rd, 8'h3C);

        // Full sequence against the RAM slave; stray start on frame cycle 4.
        run_frame(2'b00, 8'h10, -1, -1);
        run_frame(2'b01, 8'h77, 3, -1);
        run_frame(2'b10, 8'h10, -1, -1);
        run_frame(2'b11, 8'hFF, -1, -1);
        check("rd_77", exp_rd, 8'h77);

        // start during DONE must be dropped.
        start = 1'b1;
        cmd   = 2'b00;
        data  = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 8'(busy), 8'd0);
        check("done_start_ssn", 8'(SS_n), 8'd1);
        check("hold_rddata", rd_data, exp_rd);

        // Reset in third SHIFT_IN cycle, then a normal write-data frame.
        run_frame(2'b11, 8'h00, -1, 10 + TURN + 2);
        run_frame(2'b01, 8'h9E, -1, -1);
        check("post_rst_rddata", rd_data, 8'h00);

        for (int n = 0; n < 30; n++) begin
            logic [1:0] rc;
            int         rinj;
            rc   = 2'($urandom_range(0, 3));
            rinj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
            run_frame(rc, 8'($urandom_range(0, 15)), rinj, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
